activation_lut_writer: RTL and testbench
========================================

Name: activation_lut_writer

Overview:
- Sequential loader for a RAM-based activation lookup table; the write-side counterpart of the fixed activation LUTs.
- Accepts a valid/ready stream of table entries after a start pulse.
- Writes the entries to consecutive table addresses 0..TABLE_DEPTH-1 through a registered write port, then signals completion.
- Sits between the host/config stream and a programmable activation LUT, so tanhshrink-style tables can be reloaded at runtime.

Parameters:
- DATA_IN_0_PRECISION_0, 8, width of one table entry (bits).
- ADDR_WIDTH, 8, width of the table address.
- TABLE_DEPTH, 256, number of entries per load; must satisfy 1 <= TABLE_DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  single-cycle request to begin a load
- abort  input  1  terminate the current load
- data_in_0  input  DATA_IN_0_PRECISION_0  table entry
- data_in_0_valid  input  1  entry valid
- data_in_0_ready  output  1  writer can accept an entry
- lut_wr_en  output  1  table write strobe
- lut_wr_addr  output  ADDR_WIDTH  table write address
- lut_wr_data  output  DATA_IN_0_PRECISION_0  table write data
- busy  output  1  load in progress
- done  output  1  one-cycle pulse when a full load completes
- count  output  ADDR_WIDTH+1  entries written in current/last load
- mono_err  output  1  sticky monotonicity error (see Optional Feature)

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values (registers cleared on the rst cycle edge):
  - state IDLE
  - lut_wr_en = 0, lut_wr_addr = 0, lut_wr_data = 0
  - done = 0, count = 0, mono_err = 0
  - internal address = 0
  - busy and data_in_0_ready are 0 while in IDLE.
- States: IDLE, LOAD, DONE.
- IDLE:
  - data_in_0_ready = 0 and busy = 0.
  - start = 1 moves to LOAD. The internal address is set to 0, count to 0, and mono_err is cleared.
  - abort is ignored in IDLE.
- LOAD:
  - busy = 1.
  - data_in_0_ready = !abort (combinational).
  - Handshake = data_in_0_valid & data_in_0_ready.
  - On a handshake, the next cycle drives: lut_wr_en = 1, lut_wr_addr = current address, lut_wr_data = data_in_0. Write latency is 1 cycle.
  - The address increments on each handshake. count increments on the cycle lut_wr_en is asserted.
  - A handshake at address TABLE_DEPTH-1 moves to DONE.
  - start while in LOAD is ignored.
- Abort in LOAD:
  - abort = 1 moves to IDLE with no done pulse.
  - The same-cycle beat is not accepted, because ready is 0.
  - A write registered from the previous cycle still completes.
  - count then holds the number of entries actually written.
- DONE:
  - Entered with the last write strobe in flight; busy = 1.
  - The cycle after entry, done = 1 for exactly one cycle, state returns to IDLE, busy = 0.
  - count = TABLE_DEPTH when done asserts.
  - start and abort are ignored in DONE.
- Data path:
  - lut_wr_en is 0 on every cycle without a registered handshake.
  - lut_wr_addr and lut_wr_data hold their last value when not writing.
- Address rules:
  - The address never exceeds TABLE_DEPTH-1.
  - When TABLE_DEPTH = 2**ADDR_WIDTH, no wrap is observable, because the state exits after the last entry.
- Reset mid-load: all state is cleared immediately and no further writes or done pulse occur.
- Valid without ready: the upstream holds data_in_0 stable; the writer must not sample it.

Optional Feature:
- Macro: LUT_MONOTONIC_CHECK_EN.
- Enabled:
  - Each accepted entry at address > 0 is compared, unsigned, with the previously accepted entry of the same load.
  - If the new entry is smaller, mono_err sets on the following cycle, together with its lut_wr_en.
  - mono_err is sticky until the next start or rst.
  - The write still occurs.
- Disabled: mono_err is tied to 0 and no comparator or previous-entry register exists.

Test Plan:
- Full load: rst, then start, then stream entries with value(i) = (i>=16) ? i-16 : 0, valid held high, TABLE_DEPTH = 256.
  - Expect 256 writes at addresses 0..255 with matching data, each one cycle after its handshake.
  - Expect done high for 1 cycle, two cycles after the last handshake, with count = 256 and mono_err = 0.
- Backpressure/bubbles: random valid gaps (about 50%).
  - Expect lut_wr_en only after handshakes, consecutive addresses with no skips, and final count = 256.
- Abort: abort asserted on the cycle the 10th beat is valid.
  - Expect exactly 9 writes (addresses 0..8), no done, count = 9, and IDLE with ready = 0.
  - A following start then reloads from address 0.
- Ignored controls: start pulsed mid-LOAD, and abort pulsed in IDLE and DONE.
  - Expect no effect on address sequence, count or done.
- Reset mid-load: rst asserted after 100 writes.
  - Expect next-cycle lut_wr_en = 0, count = 0, busy = 0, done never asserted.
- Monotonic check (macro defined): entries 0,1,2,1,3,...
  - Expect mono_err = 1 on the cycle the address-3 write strobes, staying 1 to the end of the load, and cleared by the next start.
  - With the macro undefined, mono_err = 0 throughout.

Source files
------------

// File: rtl/activation_lut_writer.sv
// activation_lut_writer
// Sequential loader for a RAM-based activation lookup table. After a start
// pulse it accepts a valid/ready stream of entries and writes them to
// addresses 0..TABLE_DEPTH-1 through a registered write port, then pulses
// done. A load can be cut short with abort.
//
// Optional build macro: LUT_MONOTONIC_CHECK_EN
//   When defined, every accepted entry after the first in a load is compared
//   (unsigned) against the previous accepted entry. A decrease sets the sticky
//   mono_err flag, which is cleared by the next start or by rst.
//   When undefined, mono_err is tied low and no comparator exists.
module activation_lut_writer #(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int ADDR_WIDTH            = 8,
  parameter int TABLE_DEPTH           = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  output logic                             lut_wr_en,
  output logic [ADDR_WIDTH-1:0]            lut_wr_addr,
  output logic [DATA_IN_0_PRECISION_0-1:0] lut_wr_data,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_WIDTH:0]              count,
  output logic                             mono_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address of the final entry; reaching it ends the load instead of wrapping.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TABLE_DEPTH - 1);

  state_t                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic                             wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]            wr_addr_q, wr_addr_d;
  logic [DATA_IN_0_PRECISION_0-1:0] wr_data_q, wr_data_d;
  logic                             done_q, done_d;
  logic [ADDR_WIDTH:0]              count_q, count_d;

  logic hs;
  logic start_load;

  // Ready only while loading; abort withdraws ready in the same cycle so the
  // beat presented alongside abort is never accepted.
  assign data_in_0_ready = (state_q == LOAD) && !abort;
  assign hs              = data_in_0_valid && data_in_0_ready;
  assign start_load      = (state_q == IDLE) && start;

  // Next-state, address sequencing, write-port and completion logic.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    // A write registered before an abort still lands, so the count keeps
    // tracking strobes regardless of the current state.
    count_d   = count_q + (ADDR_WIDTH + 1)'(wr_en_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          count_d = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_in_0;
          // Hold the address on the last entry so it never leaves the table.
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DONE: begin
        // The final strobe is in flight this cycle; done follows it.
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and write-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

`ifdef LUT_MONOTONIC_CHECK_EN
  logic [DATA_IN_0_PRECISION_0-1:0] prev_q, prev_d;
  logic                             mono_err_q, mono_err_d;

  // Track the previous accepted entry and flag any decrease within a load;
  // the flag lines up with the strobe of the offending write.
  always_comb begin
    prev_d     = prev_q;
    mono_err_d = mono_err_q;
    if (start_load) begin
      mono_err_d = 1'b0;
    end else if (hs) begin
      prev_d = data_in_0;
      if ((addr_q != '0) && (data_in_0 < prev_q)) begin
        mono_err_d = 1'b1;
      end
    end
  end

  // Monotonicity tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      mono_err_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      mono_err_q <= mono_err_d;
    end
  end

  assign mono_err = mono_err_q;
`else
  logic unused_start_load;
  assign unused_start_load = start_load;
  assign mono_err          = 1'b0;
`endif

  assign lut_wr_en   = wr_en_q;
  assign lut_wr_addr = wr_addr_q;
  assign lut_wr_data = wr_data_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign count       = count_q;

endmodule

// File: tb/tb_activation_lut_writer.sv
// Scoreboard bench for activation_lut_writer: the driver pushes one expected
// write per accepted beat, and a negedge monitor pops and compares each write.
module tb_activation_lut_writer;
  localparam int W     = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
`ifdef LUT_MONOTONIC_CHECK_EN
  localparam bit MONO_EN = 1'b1;
`else
  localparam bit MONO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, abort, valid;
  logic [W-1:0]  din;
  logic          ready, lut_wr_en, busy, done, mono_err;
  logic [AW-1:0] lut_wr_addr;
  logic [W-1:0]  lut_wr_data;
  logic [AW:0]   count;

  activation_lut_writer #(
    .DATA_IN_0_PRECISION_0(W),
    .ADDR_WIDTH(AW),
    .TABLE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .data_in_0(din), .data_in_0_valid(valid), .data_in_0_ready(ready),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .busy(busy), .done(done), .count(count), .mono_err(mono_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
    bit mono;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   cyc = 0, idx = 0, last_hs_cyc = 0;
  int   done_cnt = 0, done_cyc = 0, done_count_val = 0, d0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ramp(input int i);
    return (i >= 16) ? W'(i - 16) : '0;
  endfunction

  // Monitor: compare every write strobe against the scoreboard, log done pulses.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc       = cyc;
      done_count_val = int'(count);
    end
    if (lut_wr_en) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual_addr=%0d required=none", lut_wr_addr);
      end else begin
        mon_e = q.pop_front();
        chk("wr_addr", int'(lut_wr_addr), mon_e.addr);
        chk("wr_data", int'(lut_wr_data), mon_e.data);
        chk("wr_latency_cycle", cyc, mon_e.cyc);
        chk("mono_err_at_write", int'(mono_err), int'(mon_e.mono));
      end
    end
  end

  // Present one beat (optionally after random bubbles) until accepted.
  task automatic send(input logic [W-1:0] v, input bit bubbles, input bit st, input bit em);
    bit ok;
    ok = 1'b0;
    if (bubbles) begin
      for (int b = 0; b < 8 && $urandom_range(1) == 1; b++) begin
        @(negedge clk);
        valid = 1'b0;
        start = 1'b0;
      end
    end
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      valid = 1'b1;
      din   = v;
      start = st && (t == 0);
      #1;
      if (ready) begin
        exp_t e;
        e.addr = idx;
        e.data = int'(v);
        e.cyc  = cyc + 1;
        e.mono = em;
        q.push_back(e);
        last_hs_cyc = cyc;
        idx++;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout beat=%0d actual=no_ready required=ready", idx);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    valid = 1'b0;
    idx   = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    chk("reset_wr_en", int'(lut_wr_en), 0);
    chk("reset_wr_addr", int'(lut_wr_addr), 0);
    chk("reset_wr_data", int'(lut_wr_data), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_mono_err", int'(mono_err), 0);
    valid = 1'b1;
    #1;
    chk("reset_ready", int'(ready), 0);
    valid = 1'b0;
    rst   = 1'b0;

    // Full load with valid held high; start and abort poked in DONE/IDLE.
    d0 = done_cnt;
    start_load();
    chk("load_busy", int'(busy), 1);
    for (int i = 0; i < DEPTH; i++) send(ramp(i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    valid = 1'b0; abort = 1'b1; start = 1'b1;
    chk("busy_in_done", int'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", int'(done), 1);
    chk("count_at_done", int'(count), 256);
    chk("busy_after_done", int'(busy), 0);
    @(negedge clk);
    abort = 1'b0;
    chk("done_one_cycle", int'(done), 0);
    idle_cycles(3);
    chk("full_done_count", done_cnt - d0, 1);
    chk("full_done_timing", done_cyc, last_hs_cyc + 2);
    chk("full_done_countval", done_count_val, 256);
    chk("full_mono_err", int'(mono_err), 0);
    chk("full_queue_drained", q.size(), 0);
    chk("full_idle_busy", int'(busy), 0);

    // Random bubbles, with a start pulse in the middle of the load.
    d0 = done_cnt;
    start_load();
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b1, (i == 100), 1'b0);
    idle_cycles(5);
    chk("bubble_done_count", done_cnt - d0, 1);
    chk("bubble_done_timing", done_cyc, last_hs_cyc + 2);
    chk("bubble_count", int'(count), 256);
    chk("bubble_queue_drained", q.size(), 0);

    // Abort on the cycle the 10th beat is valid.
    d0 = done_cnt;
    start_load();
    for (int i = 0; i < 9; i++) send(8'(i + 1), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    valid = 1'b1; din = 8'hAA; abort = 1'b1;
    #1;
    chk("abort_ready_low", int'(ready), 0);
    chk("abort_busy", int'(busy), 1);
    @(negedge clk);
    abort = 1'b0; valid = 1'b0;
    idle_cycles(3);
    chk("abort_count", int'(count), 9);
    chk("abort_busy_after", int'(busy), 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_queue_drained", q.size(), 0);
    valid = 1'b1;
    #1;
    chk("abort_idle_ready", int'(ready), 0);
    valid = 1'b0;

    // Reload from address 0, then reset after 100 writes.
    d0 = done_cnt;
    start_load();
    for (int i = 0; i < 100; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_wr_en", int'(lut_wr_en), 0);
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_busy", int'(busy), 0);
    idle_cycles(5);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_queue_drained", q.size(), 0);

    // Monotonicity: 0,1,2,1,3,4,...
    start_load();
    for (int i = 0; i < DEPTH; i++)
      send((i == 3) ? 8'd1 : 8'(i), 1'b0, 1'b0, MONO_EN && (i >= 3));
    idle_cycles(4);
    chk("mono_sticky_end", int'(mono_err), int'(MONO_EN));
    chk("mono_count", int'(count), 256);
    start_load();
    chk("mono_cleared_by_start", int'(mono_err), 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("final_busy", int'(busy), 0);
    chk("final_queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
